// File: rtl/mem_arbiter_if.sv
// Request/response and memory-bus bundle shared by the requesters and mem_arbiter.
// master = requester/memory side (testbench or SoC glue), slave = the arbiter.
interface mem_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS-1:0]        req_ready;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*DATA_W-1:0] req_wdata;
    logic [NUM_PORTS-1:0]        req_we;
    logic [NUM_PORTS-1:0]        rsp_valid;
    logic [DATA_W-1:0]           rsp_rdata;
    logic [ADDR_W-1:0]           memory__address;
    logic [DATA_W-1:0]           memory__write_data;
    logic                        memory__write_enable;
    logic [DATA_W-1:0]           memory__read_data;

    modport master (
        output req_valid, req_addr, req_wdata, req_we, memory__read_data,
        input  req_ready, rsp_valid, rsp_rdata,
               memory__address, memory__write_data, memory__write_enable
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, memory__read_data,
        output req_ready, rsp_valid, rsp_rdata,
               memory__address, memory__write_data, memory__write_enable
    );
endinterface

// File: rtl/mem_arbiter.sv
// Multi-port front-end onto a single fixed-latency memory: one grant per cycle,
// read/write tags tracked through a READ_LATENCY-deep pipe to route responses back.
module mem_arbiter #(
    parameter int NUM_PORTS    = 2,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int ARB_MODE     = 0
) (
    input  logic             clk,
    input  logic             reset,
    mem_arbiter_if.slave     bus
);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int LAST  = READ_LATENCY - 1;

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    logic             grant_we;

    logic [READ_LATENCY-1:0]            tag_valid;
    logic [READ_LATENCY-1:0][IDX_W-1:0] tag_port;
    logic [READ_LATENCY-1:0]            tag_we;

    logic [NUM_PORTS-1:0] req_ready;
    logic [NUM_PORTS-1:0] rsp_valid;
    logic [DATA_W-1:0]    rsp_rdata;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic                 mem_we;

    // Scan from the lowest priority upward so the highest-priority hit is written last.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (!reset) begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (ARB_MODE == 1) begin
                    cand = IDX_W'(i);
                end else begin
                    cand = IDX_W'((int'(ptr) + i) % NUM_PORTS);
                end
                if (bus.req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        grant_we  = 1'b0;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
            mem_addr  = bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
            mem_wdata = bus.req_wdata[grant_idx*DATA_W +: DATA_W];
            mem_we    = bus.req_we[grant_idx];
            grant_we  = bus.req_we[grant_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (ARB_MODE == 0 && grant_any) begin
            if (grant_idx == IDX_W'(NUM_PORTS - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_valid <= '0;
            tag_port  <= '0;
            tag_we    <= '0;
        end else begin
            tag_valid[0] <= grant_any;
            tag_port[0]  <= grant_idx;
            tag_we[0]    <= grant_we;
            for (int s = 1; s < READ_LATENCY; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_port[s]  <= tag_port[s-1];
                tag_we[s]    <= tag_we[s-1];
            end
        end
    end

    // Tags can still be live during the first reset cycle, so the strobe is gated too.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (!reset && tag_valid[LAST]) begin
            rsp_valid[tag_port[LAST]] = 1'b1;
            if (!tag_we[LAST]) begin
                rsp_rdata = bus.memory__read_data;
            end
        end
    end

    assign bus.req_ready            = req_ready;
    assign bus.rsp_valid            = rsp_valid;
    assign bus.rsp_rdata            = rsp_rdata;
    assign bus.memory__address      = mem_addr;
    assign bus.memory__write_data   = mem_wdata;
    assign bus.memory__write_enable = mem_we;
endmodule

// File: tb/tb_mem_arbiter.sv
// Checks a round-robin (4 ports, latency 3) and a fixed-priority (4 ports, latency 1)
// arbiter against a due-cycle response schedule, with directed and random traffic.
module tb_mem_arbiter;
    logic clk;
    logic reset;

    logic [3:0]  rv[2];
    logic [3:0]  rwe[2];
    logic [31:0] raddr[2][4];
    logic [31:0] rwd[2][4];
    logic [31:0] rdata[2];

    mem_arbiter_if #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32)) bus_rr ();
    mem_arbiter_if #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32)) bus_fx ();

    assign bus_rr.req_valid         = rv[0];
    assign bus_rr.req_we            = rwe[0];
    assign bus_rr.req_addr          = {raddr[0][3], raddr[0][2], raddr[0][1], raddr[0][0]};
    assign bus_rr.req_wdata         = {rwd[0][3], rwd[0][2], rwd[0][1], rwd[0][0]};
    assign bus_rr.memory__read_data = rdata[0];

    assign bus_fx.req_valid         = rv[1];
    assign bus_fx.req_we            = rwe[1];
    assign bus_fx.req_addr          = {raddr[1][3], raddr[1][2], raddr[1][1], raddr[1][0]};
    assign bus_fx.req_wdata         = {rwd[1][3], rwd[1][2], rwd[1][1], rwd[1][0]};
    assign bus_fx.memory__read_data = rdata[1];

    mem_arbiter #(
        .NUM_PORTS(4), .ADDR_W(32), .DATA_W(32), .READ_LATENCY(3), .ARB_MODE(0)
    ) u_rr (
        .clk(clk), .reset(reset), .bus(bus_rr)
    );

    mem_arbiter #(
        .NUM_PORTS(4), .ADDR_W(32), .DATA_W(32), .READ_LATENCY(1), .ARB_MODE(1)
    ) u_fx (
        .clk(clk), .reset(reset), .bus(bus_fx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: round-robin pointer plus a table of responses keyed by due cycle.
    int mptr = 0;
    bit sv[2][16];
    int sp[2][16];
    bit sw[2][16];
    int sdue[2][16];
    int lg[2];

    logic [3:0]  obs_ready[2];
    logic [3:0]  obs_rsp[2];
    logic [31:0] obs_rdata[2];
    logic [31:0] obs_addr[2];
    logic [31:0] obs_wdata[2];
    logic        obs_we[2];

    task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int lat(int d);
        return (d == 0) ? 3 : 1;
    endfunction

    function automatic int exp_grant(int d);
        int p;
        if (reset) return -1;
        for (int i = 0; i < 4; i++) begin
            p = (d == 0) ? (mptr + i) % 4 : i;
            if (rv[d][p]) return p;
        end
        return -1;
    endfunction

    task automatic tick();
        int          g;
        int          slot;
        int          ds;
        logic [3:0]  e_rsp;
        logic [31:0] e_rd;
        string       nm;
        @(negedge clk);
        obs_ready[0] = bus_rr.req_ready;          obs_ready[1] = bus_fx.req_ready;
        obs_rsp[0]   = bus_rr.rsp_valid;          obs_rsp[1]   = bus_fx.rsp_valid;
        obs_rdata[0] = bus_rr.rsp_rdata;          obs_rdata[1] = bus_fx.rsp_rdata;
        obs_addr[0]  = bus_rr.memory__address;    obs_addr[1]  = bus_fx.memory__address;
        obs_wdata[0] = bus_rr.memory__write_data; obs_wdata[1] = bus_fx.memory__write_data;
        obs_we[0]    = bus_rr.memory__write_enable;
        obs_we[1]    = bus_fx.memory__write_enable;
        for (int d = 0; d < 2; d++) begin
            nm = (d == 0) ? "rr" : "fx";
            g = exp_grant(d);
            check_val({nm, " req_ready"}, 64'(obs_ready[d]), (g >= 0) ? 64'(4'b0001 << g) : 64'd0);
            check_val({nm, " mem_addr"},  64'(obs_addr[d]),  (g >= 0) ? 64'(raddr[d][g]) : 64'd0);
            check_val({nm, " mem_wdata"}, 64'(obs_wdata[d]), (g >= 0) ? 64'(rwd[d][g]) : 64'd0);
            check_val({nm, " mem_we"},    64'(obs_we[d]),    (g >= 0) ? 64'(rwe[d][g]) : 64'd0);
            slot  = cyc % 16;
            e_rsp = 4'b0000;
            e_rd  = 32'h0;
            if (!reset && sv[d][slot] && sdue[d][slot] == cyc) begin
                e_rsp = 4'b0001 << sp[d][slot];
                e_rd  = sw[d][slot] ? 32'h0 : rdata[d];
            end
            check_val({nm, " rsp_valid"}, 64'(obs_rsp[d]),   64'(e_rsp));
            check_val({nm, " rsp_rdata"}, 64'(obs_rdata[d]), 64'(e_rd));
            sv[d][slot] = 1'b0;
            if (reset) begin
                for (int k = 0; k < 16; k++) sv[d][k] = 1'b0;
                if (d == 0) mptr = 0;
            end else if (g >= 0) begin
                ds = (cyc + lat(d)) % 16;
                sv[d][ds]   = 1'b1;
                sp[d][ds]   = g;
                sw[d][ds]   = rwe[d][g];
                sdue[d][ds] = cyc + lat(d);
                if (d == 0) mptr = (g + 1) % 4;
            end
            lg[d] = g;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            rv[d]    = 4'b0;
            rwe[d]   = 4'b0;
            rdata[d] = $urandom;
            for (int p = 0; p < 4; p++) begin
                raddr[d][p] = 32'h0;
                rwd[d][p]   = 32'h0;
            end
        end
    endtask

    task automatic rand_stim();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 4; p++) begin
                if (rv[d][p] && lg[d] == p) rv[d][p] = 1'b0;
                if (!rv[d][p] && $urandom_range(0, 99) < 60) begin
                    rv[d][p]    = 1'b1;
                    raddr[d][p] = $urandom;
                    rwd[d][p]   = $urandom;
                    rwe[d][p]   = 1'($urandom_range(0, 1));
                end
            end
            rdata[d] = $urandom;
        end
        reset = ($urandom_range(0, 99) < 3);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        lg[0] = -1;
        lg[1] = -1;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 16; k++) sv[d][k] = 1'b0;

        // Reset held with every port requesting.
        rv[0] = 4'b1111;
        rv[1] = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("rst ready", 64'(obs_ready[0]), 64'd0);
            check_val("rst we",    64'(obs_we[0]),    64'd0);
        end
        reset = 1'b0;
        tick();
        check_val("rst first grant", 64'(obs_ready[0]), 64'b0001);

        // Round-robin rotation with all ports requesting continuously, wrapping twice.
        for (int i = 1; i < 9; i++) begin
            tick();
            check_val("rr rotation", 64'(obs_ready[0]), 64'(4'b0001 << (i % 4)));
            check_val("fx lowest wins", 64'(obs_ready[1]), 64'b0001);
        end

        // Fixed priority: port 1 starves port 3 until it withdraws.
        idle_inputs();
        rv[1] = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("fx port1 wins", 64'(obs_ready[1]), 64'b0010);
        end
        rv[1] = 4'b1000;
        tick();
        check_val("fx port3 after", 64'(obs_ready[1]), 64'b1000);
        rv[1] = 4'b0000;
        for (int i = 0; i < 4; i++) tick();

        // Latency routing on the latency-3 instance.
        rv[0] = 4'b0100;
        raddr[0][2] = 32'h100;
        tick();
        check_val("lat issue ready", 64'(obs_ready[0]), 64'b0100);
        check_val("lat issue addr",  64'(obs_addr[0]),  64'h100);
        rv[0] = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("lat early rsp", 64'(obs_rsp[0]), 64'd0);
        end
        rdata[0] = 32'hDEADBEEF;
        tick();
        check_val("lat rsp valid", 64'(obs_rsp[0]),   64'b0100);
        check_val("lat rsp data",  64'(obs_rdata[0]), 64'hDEADBEEF);
        rdata[0] = 32'h12345678;
        tick();
        check_val("lat rsp once", 64'(obs_rsp[0]), 64'd0);

        // Back-to-back reads from ports 0 and 1 return in issue order.
        rv[0] = 4'b0011;
        raddr[0][0] = 32'h200;
        raddr[0][1] = 32'h300;
        tick();
        check_val("b2b grant0", 64'(obs_ready[0]), 64'b0001);
        rv[0] = 4'b0010;
        tick();
        check_val("b2b grant1", 64'(obs_ready[0]), 64'b0010);
        rv[0] = 4'b0000;
        tick();
        rdata[0] = 32'h11111111;
        tick();
        check_val("b2b rsp0", 64'(obs_rsp[0]),   64'b0001);
        check_val("b2b dat0", 64'(obs_rdata[0]), 64'h11111111);
        rdata[0] = 32'h22222222;
        tick();
        check_val("b2b rsp1", 64'(obs_rsp[0]),   64'b0010);
        check_val("b2b dat1", 64'(obs_rdata[0]), 64'h22222222);

        // Write acknowledge on the latency-1 instance.
        rv[1] = 4'b0010;
        rwe[1][1] = 1'b1;
        raddr[1][1] = 32'h40;
        rwd[1][1] = 32'h55AA;
        tick();
        check_val("wr we",    64'(obs_we[1]),    64'd1);
        check_val("wr addr",  64'(obs_addr[1]),  64'h40);
        check_val("wr wdata", 64'(obs_wdata[1]), 64'h55AA);
        rv[1] = 4'b0000;
        rdata[1] = 32'hFFFFFFFF;
        tick();
        check_val("wr ack valid", 64'(obs_rsp[1]),   64'b0010);
        check_val("wr ack data",  64'(obs_rdata[1]), 64'd0);

        // Reset with reads in flight: nothing may come back, pointer restarts at 0.
        idle_inputs();
        rv[0] = 4'b1111;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rv[0] = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("flight dropped", 64'(obs_rsp[0]), 64'd0);
        end
        rv[0] = 4'b1111;
        tick();
        check_val("ptr after reset", 64'(obs_ready[0]), 64'b0001);

        // Random traffic with occasional resets.
        idle_inputs();
        for (int i = 0; i < 600; i++) begin
            rand_stim();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
